// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/latch/execute with memory waits,
// a bus-timeout fault and a retired-instruction counter.
module control_sequencer #(
  parameter int CONTROLBITS = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             opcode,
  input  logic                   z_flag,
  input  logic                   mem_ready,
  output logic [CONTROLBITS-1:0] b_sel,
  output logic [1:0]             alu_op,
  output logic                   r_wen,
  output logic                   pc_wen,
  output logic                   pc_inc,
  output logic                   ir_wen,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic                   halted,
  output logic                   bus_err,
  output logic                   illegal_op,
  output logic [15:0]            instr_count
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WW-1:0]   r_wait;
  logic            r_bus_err;
  logic [15:0]     r_instr_count;
  logic            w_retire;
  logic            w_timeout;
  logic            w_wait_inc;
  logic            w_wait_last;
  logic            w_is_load;
  logic [3:0]      w_op;

  assign w_op        = opcode[7:4];
  assign w_is_load   = (w_op == 4'h4);
  // The cycle whose missing mem_ready would bring the count up to TIMEOUT.
  assign w_wait_last = !mem_ready && (int'(r_wait) + 1 >= TIMEOUT);

  assign bus_err     = r_bus_err;
  assign instr_count = r_instr_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is asynchronous so outputs drop without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_bus_err     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wait_inc) r_wait <= r_wait + WW'(1);
      else            r_wait <= '0;
      if (w_timeout)  r_bus_err <= 1'b1;
      if (w_retire)   r_instr_count <= r_instr_count + 16'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    b_sel        = CONTROLBITS'(4'hF);
    alu_op       = 2'b00;
    r_wen        = 1'b0;
    pc_wen       = 1'b0;
    pc_inc       = 1'b0;
    ir_wen       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    halted       = 1'b0;
    illegal_op   = 1'b0;
    w_retire     = 1'b0;
    w_timeout    = 1'b0;
    w_wait_inc   = 1'b0;

    case (r_state)
      S_IDLE: if (start) w_state_next = S_FETCH;

      S_FETCH: begin
        b_sel  = CONTROLBITS'(4'h1);
        mem_rd = 1'b1;
        if (mem_ready) begin
          w_state_next = S_LATCH;
        end else if (w_wait_last) begin
          w_state_next = S_HALT;
          w_timeout    = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_LATCH: begin
        ir_wen       = 1'b1;
        pc_inc       = 1'b1;
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        b_sel        = CONTROLBITS'(opcode[3:0]);
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
        case (w_op)
          4'h0: ;
          4'h1: r_wen = 1'b1;
          4'h2: begin alu_op = 2'b01; r_wen = 1'b1; end
          4'h3: begin alu_op = 2'b10; r_wen = 1'b1; end
          4'h4, 4'h5: begin w_state_next = S_MEM; w_retire = 1'b0; end
          4'h6: pc_wen = 1'b1;
          4'h7: pc_wen = z_flag;
          4'hF: w_state_next = S_HALT;
          default: illegal_op = 1'b1;
        endcase
      end

      S_MEM: begin
        if (w_is_load) begin
          mem_rd = 1'b1;
          b_sel  = CONTROLBITS'(4'h7);
        end else begin
          mem_wr = 1'b1;
          b_sel  = CONTROLBITS'(opcode[3:0]);
        end
        if (mem_ready) begin
          w_state_next = w_is_load ? S_WB : S_FETCH;
          w_retire     = !w_is_load;
        end else if (w_wait_last) begin
          w_state_next = S_HALT;
          w_timeout    = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_WB: begin
        b_sel        = '0;
        r_wen        = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (start && !r_bus_err) w_state_next = S_FETCH;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter CONTROLBITS, default 4: width of b_sel; matches the B-bus select field.
REQ-002 Parameter TIMEOUT, default 15: maximum number of cycles the block waits for mem_ready before it faults.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  level; begins or resumes instruction execution.
REQ-006 opcode  input  8  IR contents; [7:4] op, [3:0] B-source code.
REQ-007 z_flag  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 b_sel  output  CONTROLBITS  B-bus source select (0 MDR, 1 PC, 2 MBRU, 3-7 R1,R2,R3,R4,R; 8-15 bus reads zero).
REQ-010 alu_op  output  2  00 pass B, 01 R+B, 10 R-B.
REQ-011 r_wen, pc_wen, pc_inc, ir_wen, mem_rd, mem_wr  output  1 each  datapath strobes.
REQ-012 halted, bus_err, illegal_op  output  1 each  status.
REQ-013 instr_count  output  16  number of retired instructions.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, LATCH, EXEC, MEM, WB and HALT; outputs are decoded from the registered state and opcode (Moore).
REQ-015 Every strobe not listed for a state SHALL be 0, and b_sel SHALL be 4'hF in IDLE and HALT.
REQ-016 IDLE SHALL go to FETCH when start=1 and stay in IDLE otherwise.
REQ-017 FETCH SHALL drive b_sel=1 and mem_rd=1; it goes to LATCH on mem_ready=1 and holds otherwise.
REQ-018 LATCH SHALL assert ir_wen=1 and pc_inc=1 for exactly one cycle, then go to EXEC.
REQ-019 EXEC SHALL decode op (b_sel=opcode[3:0]) as follows:
- 0 NOP: no strobes.
- 1 MOV: alu_op=00, r_wen=1.
- 2 ADD: alu_op=01, r_wen=1.
- 3 SUB: alu_op=10, r_wen=1.
- 4 LOAD: go to MEM.
- 5 STORE: go to MEM.
- 6 JMP: pc_wen=1.
- 7 JZ: pc_wen=z_flag.
- F HALT: go to HALT.
REQ-020 After ops 0-3 and 6-7, EXEC SHALL go to FETCH.
REQ-021 An op in 8-E SHALL pulse illegal_op=1 for one EXEC cycle, be treated as NOP and be counted as retired.
REQ-022 MEM for LOAD SHALL drive mem_rd=1 and b_sel=7; for STORE it drives mem_wr=1 and b_sel=opcode[3:0].
REQ-023 MEM SHALL hold until mem_ready=1; LOAD then goes to WB, and STORE goes to FETCH.
REQ-024 WB SHALL drive b_sel=0, alu_op=00 and r_wen=1 for one cycle, then go to FETCH.
REQ-025 instr_count SHALL increment by 1 on the last cycle of each instruction (EXEC for single-cycle ops, MEM for STORE, WB for LOAD, EXEC for HALT), wrapping from 16'hFFFF to 0.
REQ-026 Latency with mem_ready already high SHALL be 3 cycles for ALU, jump, NOP and HALT ops, 4 cycles for STORE and 5 cycles for LOAD.
REQ-027 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-028 If the wait counter reaches TIMEOUT, the FSM SHALL go to HALT, set bus_err=1 (sticky until reset) and leave instr_count unchanged.
REQ-029 mem_ready arriving in the same cycle the count reaches TIMEOUT SHALL count as success, not a timeout.
REQ-030 In HALT, halted SHALL be 1.
REQ-031 start=1 in HALT with bus_err=0 SHALL go to FETCH without modifying the PC; with bus_err=1, HALT SHALL be left only by reset.
REQ-032 start SHALL be ignored in every state other than IDLE and HALT.
REQ-033 mem_rd and mem_wr SHALL never both be 1.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, b_sel=4'hF, all strobes 0, halted=0, bus_err=0, illegal_op=0, instr_count=0 and wait counter 0, regardless of the current state, including mid-MEM.
REQ-035 After rst_n rises, the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-036 mem_ready tied 1, start pulse, opcode=8'h23 -> FETCH (b_sel=1, mem_rd), LATCH (ir_wen, pc_inc), EXEC (b_sel=3, alu_op=01, r_wen); instr_count=1 after 3 cycles.
REQ-037 opcode=8'h47, mem_ready low 3 cycles in MEM -> mem_rd and b_sel=7 held 4 cycles, then WB with b_sel=0 and r_wen=1; instr_count increments once.
REQ-038 opcode=8'h75 with z_flag=0, then z_flag=1 -> pc_wen=0 on the first, pc_wen=1 with b_sel=5 on the second.
REQ-039 mem_ready held 0 in FETCH with TIMEOUT=15 -> HALT after 15 wait cycles, bus_err=1, halted=1; a later start has no effect.
REQ-040 opcode=8'h90 -> one-cycle illegal_op pulse, no strobes, instr_count+1; opcode=8'hF0 -> halted=1; start -> FETCH resumes.
REQ-041 rst_n dropped asynchronously mid-MEM of a STORE -> mem_wr falls before the next clk edge, and all outputs read their REQ-034 values.
